// File: rtl/bht_ctrl_pkg.sv
// Shared types and defaults for the BHT update controller.
// Contents:
//   BHT_NR_ROWS / BHT_GHR_BITS / BHT_VLEN  default table geometry
//   bht_ctrl_state_e                       controller state (CLEAR sweep / RUN)
//   bht_upd_req_t                          one queued table update {pc, taken}
package bht_ctrl_pkg;

    localparam int unsigned BHT_NR_ROWS  = 512;
    localparam int unsigned BHT_GHR_BITS = 10;
    localparam int unsigned BHT_VLEN     = 64;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } bht_ctrl_state_e;

    // The PC field is sized for the widest supported VLEN; narrower
    // configurations use the low bits.
    typedef struct packed {
        logic [BHT_VLEN-1:0] pc;
        logic                taken;
    } bht_upd_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter.
// Ports:
//   req_i       request vector, one bit per requester
//   ptr_i       port with highest priority this cycle
//   en_i        when low no grant is issued
//   gnt_o       one-hot grant (or zero)
//   next_ptr_o  pointer to load if the grant is accepted (winner + 1 mod N)
module rr_arbiter #(
    parameter int unsigned NR_PORTS = 2,
    parameter int unsigned PTR_W    = 1
) (
    input  logic [NR_PORTS-1:0] req_i,
    input  logic [PTR_W-1:0]    ptr_i,
    input  logic                en_i,
    output logic [NR_PORTS-1:0] gnt_o,
    output logic [PTR_W-1:0]    next_ptr_o
);

    int unsigned idx;
    logic        found;

    // NOTE: every output and temporary gets a default before the search so no
    // path through this block leaves a value held, which would infer a latch.
    always_comb begin
        gnt_o      = '0;
        next_ptr_o = ptr_i;
        found      = 1'b0;
        idx        = 0;
        // Walk the ports starting at the pointer; the first requester wins.
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            idx = (32'(ptr_i) + i) % NR_PORTS;
            if (en_i && !found && req_i[PTR_W'(idx)]) begin
                found                = 1'b1;
                gnt_o[PTR_W'(idx)]   = 1'b1;
                next_ptr_o           = PTR_W'((idx + 1) % NR_PORTS);
            end
        end
    end

endmodule

// File: rtl/bht_update_ctrl.sv
// BHT update controller: funnels branch-resolution updates from NR_PORTS
// requesters through a round-robin arbiter into a small FIFO, drains the FIFO
// into the table's single update port, sweeps every row clear after reset and
// flush, and keeps the global history register used for gshare indexing.
// Optional build macro: BHT_UPD_CTRL_BYPASS_EN -- when defined, a request
// granted while the FIFO is empty is presented on upd_* in the same cycle.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                drop queued updates, clear GHR, restart sweep
//   debug_mode_i           accept but drop requests (no training)
//   req_valid_i/pc/taken   per-port update requests
//   req_ready_o            per-port accept (one-hot or zero)
//   upd_valid_o/ready_i    update handshake towards the BHT
//   upd_pc_o, upd_taken_o  update payload (FIFO head)
//   clr_valid_o, clr_idx_o row clear command during the sweep
//   ghr_o                  global history, newest outcome in bit 0
//   busy_o                 sweeping or updates pending
module bht_update_ctrl
    import bht_ctrl_pkg::*;
#(
    parameter int unsigned NR_PORTS   = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NR_ROWS    = BHT_NR_ROWS,
    parameter int unsigned GHR_BITS   = BHT_GHR_BITS,
    parameter int unsigned VLEN       = BHT_VLEN
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    input  logic                               debug_mode_i,
    input  logic [NR_PORTS-1:0]                req_valid_i,
    input  logic [NR_PORTS-1:0][VLEN-1:0]      req_pc_i,
    input  logic [NR_PORTS-1:0]                req_taken_i,
    output logic [NR_PORTS-1:0]                req_ready_o,
    output logic                               upd_valid_o,
    input  logic                               upd_ready_i,
    output logic [VLEN-1:0]                    upd_pc_o,
    output logic                               upd_taken_o,
    output logic                               clr_valid_o,
    output logic [$clog2(NR_ROWS)-1:0]         clr_idx_o,
    output logic [GHR_BITS-1:0]                ghr_o,
    output logic                               busy_o
);

    localparam int unsigned IDX_W = $clog2(NR_ROWS);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned RR_W  = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    bht_ctrl_state_e     state_q, state_d;
    logic [IDX_W-1:0]    clr_idx_q, clr_idx_d;

    bht_upd_req_t        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]      count_q;
    logic                fifo_empty, fifo_full;

    logic [RR_W-1:0]     rr_ptr_q, rr_ptr_next;
    logic [NR_PORTS-1:0] grant;
    logic                arb_en, handshake, push, pop, upd_fire;
    bht_upd_req_t        win_req, head;

    logic [GHR_BITS-1:0] ghr_q;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));

    // ------------------------------------------------------------------
    // Arbitration: only in RUN and only while there is room in the FIFO.
    // A pop in the same cycle does not free a slot for the requesters.
    // ------------------------------------------------------------------
    assign arb_en = (state_q == RUN) && !fifo_full;

    rr_arbiter #(
        .NR_PORTS (NR_PORTS),
        .PTR_W    (RR_W)
    ) i_rr_arbiter (
        .req_i      (req_valid_i),
        .ptr_i      (rr_ptr_q),
        .en_i       (arb_en),
        .gnt_o      (grant),
        .next_ptr_o (rr_ptr_next)
    );

    assign req_ready_o = grant;
    assign handshake   = |grant;

    always_comb begin
        win_req = '0;
        for (int unsigned i = 0; i < NR_PORTS; i++) begin
            if (grant[i]) begin
                win_req.pc    = BHT_VLEN'(req_pc_i[i]);
                win_req.taken = req_taken_i[i];
            end
        end
    end

    assign head = fifo_mem[rd_ptr_q];
    assign pop  = !fifo_empty && upd_ready_i && !flush_i;

`ifdef BHT_UPD_CTRL_BYPASS_EN
    // An empty FIFO lets the granted request straight through; it is only
    // queued when the table does not take it this cycle.
    logic bypass;
    assign bypass      = fifo_empty && handshake && !debug_mode_i;
    assign upd_valid_o = !fifo_empty || bypass;
    assign upd_pc_o    = fifo_empty ? win_req.pc[VLEN-1:0] : head.pc[VLEN-1:0];
    assign upd_taken_o = fifo_empty ? win_req.taken : head.taken;
    assign push        = handshake && !debug_mode_i && !flush_i &&
                         !(bypass && upd_ready_i);
`else
    assign upd_valid_o = !fifo_empty;
    assign upd_pc_o    = head.pc[VLEN-1:0];
    assign upd_taken_o = head.taken;
    assign push        = handshake && !debug_mode_i && !flush_i;
`endif

    assign upd_fire = upd_valid_o && upd_ready_i && !flush_i;

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        clr_valid_o = (state_q == CLEAR);
        if (flush_i) begin
            state_d   = CLEAR;
            clr_idx_d = '0;
        end else if (state_q == CLEAR) begin
            // Index wraps to 0 on the last row since NR_ROWS is a power of 2.
            clr_idx_d = clr_idx_q + IDX_W'(1);
            if (clr_idx_q == IDX_W'(NR_ROWS - 1)) begin
                state_d = RUN;
            end
        end
    end

    assign clr_idx_o = clr_idx_q;

    // ------------------------------------------------------------------
    // FIFO control, RR pointer and global history
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
            ghr_q    <= '0;
        end else begin
            if (handshake) begin
                rr_ptr_q <= rr_ptr_next;
            end
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                ghr_q    <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                if (push && !pop)      count_q <= count_q + (PTR_W+1)'(1);
                else if (!push && pop) count_q <= count_q - (PTR_W+1)'(1);
                if (upd_fire) begin
                    ghr_q <= {ghr_q[GHR_BITS-2:0], upd_taken_o};
                end
            end
        end
    end

    // NOTE: the storage array has no reset; count_q alone decides which
    // entries are meaningful, so resetting it would only cost flops.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= win_req;
        end
    end

    assign ghr_o  = ghr_q;
    assign busy_o = (state_q == CLEAR) || !fifo_empty;

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Self-checking bench for bht_update_ctrl (NR_ROWS=16, 2 ports, depth 4).
// A driver issues directed and random stimulus and pushes expected updates
// into a queue; a separate monitor compares every update the DUT presents.
module tb_bht_update_ctrl;

    localparam int NP    = 2;
    localparam int DEPTH = 4;
    localparam int ROWS  = 16;
    localparam int GB    = 10;
    localparam int VL    = 64;

    logic                  clk = 1'b0;
    logic                  rst_ni;
    logic                  flush_i, debug_mode_i, upd_ready_i;
    logic [NP-1:0]         req_valid_i, req_taken_i, req_ready_o;
    logic [NP-1:0][VL-1:0] req_pc_i;
    logic                  upd_valid_o, upd_taken_o, clr_valid_o, busy_o;
    logic [VL-1:0]         upd_pc_o;
    logic [$clog2(ROWS)-1:0] clr_idx_o;
    logic [GB-1:0]         ghr_o;

    always #5 clk = ~clk;

    bht_update_ctrl #(
        .NR_PORTS   (NP),
        .FIFO_DEPTH (DEPTH),
        .NR_ROWS    (ROWS),
        .GHR_BITS   (GB),
        .VLEN       (VL)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .debug_mode_i (debug_mode_i),
        .req_valid_i  (req_valid_i),
        .req_pc_i     (req_pc_i),
        .req_taken_i  (req_taken_i),
        .req_ready_o  (req_ready_o),
        .upd_valid_o  (upd_valid_o),
        .upd_ready_i  (upd_ready_i),
        .upd_pc_o     (upd_pc_o),
        .upd_taken_o  (upd_taken_o),
        .clr_valid_o  (clr_valid_o),
        .clr_idx_o    (clr_idx_o),
        .ghr_o        (ghr_o),
        .busy_o       (busy_o)
    );

    typedef struct {
        logic [VL-1:0] pc;
        logic          taken;
    } ent_t;

    // Reference model state
    ent_t          exp_q[$];
    ent_t          byp_ent;
    bit            byp_v    = 1'b0;
    bit            in_clear = 1'b1;
    int            idx_m    = 0;
    int            rr_m     = 0;
    logic [GB-1:0] ghr_m    = '0;
    bit            started  = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus. Entered and left at posedge+1.
    task automatic step(input logic [NP-1:0] v, input logic [NP-1:0] tk,
                        input logic [VL-1:0] p0, input logic [VL-1:0] p1,
                        input logic rdy, input logic dbg, input logic fl);
        logic [NP-1:0] exp_rdy;
        int            w;
        int            p;
        ent_t          e;
        req_valid_i    = v;
        req_taken_i    = tk;
        req_pc_i[0]    = p0;
        req_pc_i[1]    = p1;
        upd_ready_i    = rdy;
        debug_mode_i   = dbg;
        flush_i        = fl;
        exp_rdy = '0;
        w       = -1;
        if (!in_clear && exp_q.size() < DEPTH) begin
            for (int i = 0; i < NP; i++) begin
                p = (rr_m + i) % NP;
                if (w < 0 && v[p]) w = p;
            end
        end
        if (w >= 0) begin
            exp_rdy[w] = 1'b1;
            e.pc    = (w == 0) ? p0 : p1;
            e.taken = tk[w];
        end
        #1;
        check("req_ready", 64'(req_ready_o), 64'(exp_rdy));
`ifdef BHT_UPD_CTRL_BYPASS_EN
        if (w >= 0 && !dbg && exp_q.size() == 0) begin
            byp_v   = 1'b1;
            byp_ent = e;
        end
`endif
        @(negedge clk);
        #1;
        if (w >= 0) begin
            rr_m = (w + 1) % NP;
            if (!dbg && !fl && !(byp_v && rdy)) exp_q.push_back(e);
        end
        byp_v = 1'b0;
        if (fl) begin
            in_clear = 1'b1;
            idx_m    = 0;
        end else if (in_clear) begin
            if (idx_m == ROWS - 1) begin
                in_clear = 1'b0;
                idx_m    = 0;
            end else begin
                idx_m++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step('0, '0, '0, '0, rdy, 1'b0, 1'b0);
    endtask

    // Monitor: compares registered outputs and every completed update.
    initial begin
        ent_t e;
        bit   exp_v;
        wait (started);
        forever begin
            @(negedge clk);
            exp_v = (exp_q.size() != 0) || byp_v;
            check("clr_valid", 64'(clr_valid_o), 64'(in_clear));
            if (in_clear) check("clr_idx", 64'(clr_idx_o), 64'(idx_m));
            check("busy", 64'(busy_o), 64'(in_clear || exp_q.size() != 0));
            check("ghr", 64'(ghr_o), 64'(ghr_m));
            check("upd_valid", 64'(upd_valid_o), 64'(exp_v));
            if (upd_valid_o && upd_ready_i && !flush_i && exp_v) begin
                if (exp_q.size() != 0) e = exp_q.pop_front();
                else                   e = byp_ent;
                check("upd_pc", upd_pc_o, e.pc);
                check("upd_taken", 64'(upd_taken_o), 64'(e.taken));
                ghr_m = {ghr_m[GB-2:0], e.taken};
            end
            if (flush_i) begin
                exp_q.delete();
                ghr_m = '0;
            end
        end
    end

    initial begin
        logic [GB-1:0] bits;
        rst_ni       = 1'b0;
        flush_i      = 1'b0;
        debug_mode_i = 1'b0;
        upd_ready_i  = 1'b0;
        req_valid_i  = '0;
        req_taken_i  = '0;
        req_pc_i     = '0;

        // Values held during reset
        @(negedge clk);
        check("rst_clr_valid", 64'(clr_valid_o), 64'd1);
        check("rst_clr_idx", 64'(clr_idx_o), 64'd0);
        check("rst_upd_valid", 64'(upd_valid_o), 64'd0);
        check("rst_req_ready", 64'(req_ready_o), 64'd0);
        check("rst_ghr", 64'(ghr_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd1);
        @(posedge clk);
        #1;
        rst_ni  = 1'b1;
        started = 1'b1;

        // Initial sweep: 16 clear cycles, then RUN with busy low.
        idle(17, 1'b1);

        // Both ports, table stalled: grants 0,1,0,1 then full.
        for (int i = 0; i < 5; i++)
            step(2'b11, 2'b01, 64'h1000 + 64'(i), 64'h2000 + 64'(i), 1'b0, 1'b0, 1'b0);
        idle(5, 1'b1);
        check("ghr_after_drain", 64'(ghr_o), 64'h00A);

        // Restart, then single-port latency and GHR.
        step('0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        idle(17, 1'b1);
        step(2'b01, 2'b01, 64'hABCD_0000, '0, 1'b1, 1'b0, 1'b0);
        idle(1, 1'b1);
        check("ghr_single", 64'(ghr_o), 64'd1);

        // Debug mode: accepted, dropped, no history change.
        step(2'b10, 2'b10, '0, 64'hDEAD_BEE0, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1);
        check("ghr_debug", 64'(ghr_o), 64'd1);

        // Build GHR = 0x2A5 from a clean history, queue 3, then flush.
        step('0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        idle(17, 1'b1);
        bits = 10'h2A5;
        for (int i = GB - 1; i >= 0; i--)
            step(2'b01, {1'b0, bits[i]}, 64'h4000 + 64'(i), '0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1);
        check("ghr_2a5", 64'(ghr_o), 64'h2A5);
        for (int i = 0; i < 3; i++)
            step(2'b01, 2'b01, 64'h5000 + 64'(i), '0, 1'b0, 1'b0, 1'b0);
        step('0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("flush_clr_valid", 64'(clr_valid_o), 64'd1);
        check("flush_clr_idx", 64'(clr_idx_o), 64'd0);
        check("flush_upd_valid", 64'(upd_valid_o), 64'd0);
        check("flush_ghr", 64'(ghr_o), 64'd0);

        // Flush in the middle of a sweep (at row 9): restarts from 0.
        idle(9, 1'b1);
        check("mid_sweep_idx", 64'(clr_idx_o), 64'd9);
        step('0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        check("restart_idx", 64'(clr_idx_o), 64'd0);
        idle(17, 1'b1);

        // Random traffic against the reference model.
        for (int n = 0; n < 800; n++) begin
            logic [NP-1:0] v;
            logic          fl;
            fl = ($urandom_range(0, 99) == 0);
            v  = fl ? '0 : NP'($urandom_range(0, 3));
            step(v, NP'($urandom_range(0, 3)),
                 {$urandom(), $urandom()}, {$urandom(), $urandom()},
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), fl);
        end
        idle(24, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
